// File: rtl/pkg_compuertas.sv
// Shared types and constants for the logic-gate self-test sequencer.
// Bit indices follow the gate block's output numbering: salida_1 (NOT A) is bit 0.
package pkg_compuertas;

  localparam int NUM_SALIDAS  = 7;
  localparam int NUM_VECTORES = 4;
  localparam int ERR_W        = 5;

  localparam int IDX_NOT  = 0;
  localparam int IDX_AND  = 1;
  localparam int IDX_OR   = 2;
  localparam int IDX_XOR  = 3;
  localparam int IDX_NAND = 4;
  localparam int IDX_NOR  = 5;
  localparam int IDX_XNOR = 6;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    ESPERAR   = 2'd1,
    MUESTREAR = 2'd2,
    FIN       = 2'd3
  } estado_t;

  function automatic logic [2:0] popcount7(input logic [NUM_SALIDAS-1:0] v);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < NUM_SALIDAS; i++) s = s + {2'b00, v[i]};
    return s;
  endfunction

endpackage

// File: rtl/prueba_compuertas_if.sv
// Bundle between the self-test sequencer (master) and whoever drives the start
// pulse, feeds back the gate outputs and reads the results (slave).
interface prueba_compuertas_if;
  import pkg_compuertas::*;

  logic                   iniciar;
  logic [NUM_SALIDAS-1:0] salidas_dut;
  logic                   entrada_A;
  logic                   entrada_B;
  logic [1:0]             indice_vector;
  logic                   ocupado;
  logic                   terminado;
  logic                   aprobado;
  logic [ERR_W-1:0]       errores;
  logic [NUM_SALIDAS-1:0] mapa_fallas;

  modport master (
    input  iniciar, salidas_dut,
    output entrada_A, entrada_B, indice_vector, ocupado, terminado,
           aprobado, errores, mapa_fallas
  );

  modport slave (
    output iniciar, salidas_dut,
    input  entrada_A, entrada_B, indice_vector, ocupado, terminado,
           aprobado, errores, mapa_fallas
  );

endinterface

// File: rtl/modelo_compuertas.sv
// Golden combinational model of the seven two-input gates, one bit per gate.
module modelo_compuertas
  import pkg_compuertas::*;
(
  input  logic                   A,
  input  logic                   B,
  output logic [NUM_SALIDAS-1:0] expected
);

  always_comb begin
    expected            = '0;
    expected[IDX_NOT]   = ~A;
    expected[IDX_AND]   = A & B;
    expected[IDX_OR]    = A | B;
    expected[IDX_XOR]   = A ^ B;
    expected[IDX_NAND]  = ~(A & B);
    expected[IDX_NOR]   = ~(A | B);
    expected[IDX_XNOR]  = ~(A ^ B);
  end

endmodule

// File: rtl/prueba_compuertas.sv
// Self-test sequencer: sweeps A/B over 00,01,10,11, lets each vector settle,
// then compares the gate outputs against modelo_compuertas and accumulates results.
module prueba_compuertas
  import pkg_compuertas::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1  // legal range 1..15
) (
  input logic                 clk,
  input logic                 rst,
  prueba_compuertas_if.master bus
);

  localparam logic [3:0] CUENTA_FIN = 4'(SETTLE_CYCLES - 1);

  estado_t                estado;
  logic [3:0]             cuenta;
  logic [1:0]             vector;
  logic [NUM_SALIDAS-1:0] esperado;
  logic [NUM_SALIDAS-1:0] discrepancia;
  logic [ERR_W-1:0]       errores_sig;
  logic [NUM_SALIDAS-1:0] mapa_sig;

  // The reference follows the vector register, which equals the driven
  // stimulus by the time MUESTREAR is reached.
  modelo_compuertas u_modelo (
    .A        (vector[1]),
    .B        (vector[0]),
    .expected (esperado)
  );

  always_comb begin
    discrepancia = bus.salidas_dut ^ esperado;
    errores_sig  = bus.errores + ERR_W'(popcount7(discrepancia));
    mapa_sig     = bus.mapa_fallas | discrepancia;
  end

  assign bus.indice_vector = vector;

  // NOTE: every register below uses non-blocking assignment so all state
  // updates on an edge see the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado          <= REPOSO;
      cuenta          <= '0;
      vector          <= '0;
      bus.entrada_A   <= 1'b0;
      bus.entrada_B   <= 1'b0;
      bus.ocupado     <= 1'b0;
      bus.terminado   <= 1'b0;
      bus.aprobado    <= 1'b0;
      bus.errores     <= '0;
      bus.mapa_fallas <= '0;
    end else begin
      unique case (estado)
        REPOSO: begin
          if (bus.iniciar) begin
            estado          <= ESPERAR;
            vector          <= '0;
            cuenta          <= '0;
            bus.ocupado     <= 1'b1;
            bus.errores     <= '0;
            bus.mapa_fallas <= '0;
            bus.aprobado    <= 1'b0;
          end
        end

        ESPERAR: begin
          bus.entrada_A <= vector[1];
          bus.entrada_B <= vector[0];
          cuenta        <= cuenta + 4'd1;
          if (cuenta == CUENTA_FIN) estado <= MUESTREAR;
        end

        MUESTREAR: begin
          bus.errores     <= errores_sig;
          bus.mapa_fallas <= mapa_sig;
          // Flags are registered on entry to FIN so they are visible during it.
          if (vector == 2'd3) begin
            estado        <= FIN;
            bus.ocupado   <= 1'b0;
            bus.terminado <= 1'b1;
            bus.aprobado  <= (errores_sig == '0);
          end else begin
            vector <= vector + 2'd1;
            cuenta <= '0;
            estado <= ESPERAR;
          end
        end

        FIN: begin
          bus.terminado <= 1'b0;
          estado        <= REPOSO;
        end

        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_prueba_compuertas.sv
// Bench for prueba_compuertas: two instances (settle 1 and 3) driven by an emulated
// gate block with injectable faults, checked every cycle against a timeline model.
`timescale 1ns/1ps
module tb_prueba_compuertas;
  import pkg_compuertas::*;

  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [NI-1:0] iniciar;
  logic [NI-1:0] glitch;
  logic [NI-1:0] cmp_en;
  logic [6:0]    masc [NI][4];

  logic [NI-1:0] ter_o, ocu_o, apr_o;
  logic [4:0]    err_o [NI];
  logic [6:0]    map_o [NI];
  logic [1:0]    ind_o [NI];
  logic [1:0]    ent_o [NI];

  task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
    checks++;
    if (actual !== esperado) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nombre, actual, esperado);
    end
  endtask

  // Gate truth table from arithmetic on the 0/1 inputs.
  function automatic logic [6:0] puertas(input int a, input int b);
    logic [6:0] r;
    r[0] = (a == 0);
    r[1] = (a + b == 2);
    r[2] = (a + b >= 1);
    r[3] = (a + b == 1);
    r[4] = (a + b != 2);
    r[5] = (a + b == 0);
    r[6] = (a == b);
    return r;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gen
    localparam int S     = (g == 0) ? 1 : 3;
    localparam int PER   = S + 1;
    localparam int LARGO = 4 * PER;

    prueba_compuertas_if bus ();

    prueba_compuertas #(.SETTLE_CYCLES(S)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.iniciar = iniciar[g];
    assign ter_o[g]    = bus.terminado;
    assign ocu_o[g]    = bus.ocupado;
    assign apr_o[g]    = bus.aprobado;
    assign err_o[g]    = bus.errores;
    assign map_o[g]    = bus.mapa_fallas;
    assign ind_o[g]    = bus.indice_vector;
    assign ent_o[g]    = {bus.entrada_A, bus.entrada_B};

    // Timeline model: c counts cycles since the start edge (cycle 1 follows it).
    logic       activo;
    int         c;
    logic [1:0] ent0;
    int         ev [4];
    logic [6:0] mv [4];
    logic [1:0] idle_ind, idle_ent;
    int         idle_err;
    logic [6:0] idle_map;
    logic       idle_apr;

    always_comb begin
      logic [6:0] s;
      s = puertas(int'(bus.entrada_A), int'(bus.entrada_B)) ^ masc[g][{bus.entrada_A, bus.entrada_B}];
      if (glitch[g] && activo && c <= LARGO && ((c - 1) % PER) == 0) s = ~s;
      bus.salidas_dut = s;
    end

    always @(posedge clk) begin
      if (rst) begin
        activo   <= 1'b0;
        c        <= 0;
        ent0     <= '0;
        idle_ind <= '0;
        idle_ent <= '0;
        idle_err <= 0;
        idle_map <= '0;
        idle_apr <= 1'b0;
      end else if (activo) begin
        if (c == LARGO + 1) begin
          activo   <= 1'b0;
          idle_ind <= 2'd3;
          idle_ent <= 2'd3;
          idle_err <= ev[0] + ev[1] + ev[2] + ev[3];
          idle_map <= mv[0] | mv[1] | mv[2] | mv[3];
          idle_apr <= (ev[0] + ev[1] + ev[2] + ev[3]) == 0;
        end else begin
          c <= c + 1;
        end
      end else if (iniciar[g]) begin
        activo <= 1'b1;
        c      <= 1;
        ent0   <= idle_ent;
        for (int v = 0; v < 4; v++) begin
          ev[v] <= $countones(masc[g][v]);
          mv[v] <= masc[g][v];
        end
      end
    end

    always @(negedge clk) begin
      int         n, e_err, e_ind, e_ent;
      logic [6:0] e_map;
      logic       e_ocu, e_ter, e_apr;
      if (cmp_en[g]) begin
        if (activo) begin
          n = (c - 1) / PER;
          if (n > 4) n = 4;
          e_err = 0;
          e_map = '0;
          for (int v = 0; v < n; v++) begin
            e_err += ev[v];
            e_map |= mv[v];
          end
          e_ocu = (c <= LARGO);
          e_ter = (c == LARGO + 1);
          e_apr = (c == LARGO + 1) && (e_err == 0);
          e_ind = ((c - 1) / PER > 3) ? 3 : (c - 1) / PER;
          e_ent = (c < 2) ? int'(ent0) : (((c - 2) / PER > 3) ? 3 : (c - 2) / PER);
        end else begin
          e_err = idle_err;
          e_map = idle_map;
          e_ocu = 1'b0;
          e_ter = 1'b0;
          e_apr = idle_apr;
          e_ind = int'(idle_ind);
          e_ent = int'(idle_ent);
        end
        check($sformatf("g%0d c%0d ocupado", g, c), bus.ocupado, e_ocu);
        check($sformatf("g%0d c%0d terminado", g, c), bus.terminado, e_ter);
        check($sformatf("g%0d c%0d aprobado", g, c), bus.aprobado, e_apr);
        check($sformatf("g%0d c%0d errores", g, c), bus.errores, e_err);
        check($sformatf("g%0d c%0d mapa_fallas", g, c), bus.mapa_fallas, e_map);
        check($sformatf("g%0d c%0d indice_vector", g, c), bus.indice_vector, e_ind);
        check($sformatf("g%0d c%0d entradas", g, c), ent_o[g], e_ent);
      end
    end
  end

  // One start pulse, optional re-pulse at cycle rep_at; reports terminado cycle
  // and number of cycles with ocupado high (edge 0 samples iniciar).
  task automatic barrido(input int g, input int rep_at, output int ciclo, output int ocu_n);
    int n;
    ciclo = -1;
    ocu_n = 0;
    @(negedge clk);
    iniciar[g] = 1'b1;
    @(posedge clk);
    n = 0;
    while (ciclo < 0 && n < 60) begin
      @(negedge clk);
      n++;
      iniciar[g] = (n == rep_at);
      if (ocu_o[g]) ocu_n++;
      if (ter_o[g]) ciclo = n;
    end
    iniciar[g] = 1'b0;
    check($sformatf("g%0d terminado seen within budget", g), (ciclo >= 0), 1);
  endtask

  function automatic void esperado_de(input int g, output int e, output logic [6:0] m);
    e = 0;
    m = '0;
    for (int v = 0; v < 4; v++) begin
      e += $countones(masc[g][v]);
      m |= masc[g][v];
    end
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : principal
    int         ciclo, ocu_n, e_err, ter_n;
    logic [6:0] e_map;

    rst     = 1'b1;
    iniciar = '0;
    glitch  = '0;
    cmp_en  = '0;
    for (int g = 0; g < NI; g++) for (int v = 0; v < 4; v++) masc[g][v] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("reset g%0d ocupado", g), ocu_o[g], 0);
      check($sformatf("reset g%0d terminado", g), ter_o[g], 0);
      check($sformatf("reset g%0d aprobado", g), apr_o[g], 0);
      check($sformatf("reset g%0d errores", g), err_o[g], 0);
      check($sformatf("reset g%0d mapa", g), map_o[g], 0);
      check($sformatf("reset g%0d indice", g), ind_o[g], 0);
      check($sformatf("reset g%0d entradas", g), ent_o[g], 0);
    end
    rst    = 1'b0;
    cmp_en = '1;

    // Correct gates, settle 1.
    barrido(0, 0, ciclo, ocu_n);
    check("ok ciclo terminado", ciclo, 9);
    check("ok ciclos ocupado", ocu_n, 8);
    check("ok errores", err_o[0], 0);
    check("ok mapa", map_o[0], 7'h00);
    check("ok aprobado", apr_o[0], 1);

    // AND stuck at 0: only vector 11 differs. Starts right after FIN.
    masc[0][3] = 7'h02;
    barrido(0, 0, ciclo, ocu_n);
    check("and0 ciclo terminado", ciclo, 9);
    check("and0 errores", err_o[0], 1);
    check("and0 mapa", map_o[0], 7'h02);
    check("and0 aprobado", apr_o[0], 0);

    // All outputs inverted.
    for (int v = 0; v < 4; v++) masc[0][v] = 7'h7F;
    barrido(0, 0, ciclo, ocu_n);
    check("inv errores", err_o[0], 28);
    check("inv mapa", map_o[0], 7'h7F);
    check("inv aprobado", apr_o[0], 0);

    // Re-pulse at cycle 3 is ignored.
    for (int v = 0; v < 4; v++) masc[0][v] = '0;
    barrido(0, 3, ciclo, ocu_n);
    check("repulse ciclo terminado", ciclo, 9);
    check("repulse errores", err_o[0], 0);
    check("repulse aprobado", apr_o[0], 1);

    // iniciar during FIN is ignored, and no second terminado appears.
    iniciar[0] = 1'b1;
    @(negedge clk);
    iniciar[0] = 1'b0;
    ter_n = 0;
    repeat (4) begin
      @(negedge clk);
      if (ter_o[0]) ter_n++;
      check("fin iniciar ignored ocupado", ocu_o[0], 0);
    end
    check("fin iniciar no extra terminado", ter_n, 0);

    // Settle 3, outputs wrong only in the first settle cycle of each vector.
    glitch[1] = 1'b1;
    barrido(1, 0, ciclo, ocu_n);
    check("glitch ciclo terminado", ciclo, 17);
    check("glitch ciclos ocupado", ocu_n, 16);
    check("glitch errores", err_o[1], 0);
    check("glitch aprobado", apr_o[1], 1);
    glitch[1] = 1'b0;

    // Reset at cycle 5 of a failing sweep, then a clean sweep.
    for (int v = 0; v < 4; v++) masc[0][v] = 7'h7F;
    @(negedge clk);
    iniciar[0] = 1'b1;
    @(negedge clk);
    iniciar[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst ocupado", ocu_o[0], 0);
    check("rst errores", err_o[0], 0);
    check("rst mapa", map_o[0], 0);
    check("rst indice", ind_o[0], 0);
    check("rst entradas", ent_o[0], 0);
    check("rst aprobado", apr_o[0], 0);
    rst = 1'b0;
    for (int v = 0; v < 4; v++) masc[0][v] = '0;
    barrido(0, 0, ciclo, ocu_n);
    check("post-rst errores", err_o[0], 0);
    check("post-rst aprobado", apr_o[0], 1);

    // Randomized faults, re-pulses, gaps and glitches on both instances.
    for (int it = 0; it < 24; it++) begin
      int g;
      g = int'($urandom_range(0, NI - 1));
      for (int v = 0; v < 4; v++)
        masc[g][v] = ($urandom_range(0, 2) == 0) ? 7'h00 : 7'($urandom & $urandom);
      glitch[g] = 1'($urandom_range(0, 1));
      esperado_de(g, e_err, e_map);
      barrido(g, int'($urandom_range(0, 14)), ciclo, ocu_n);
      check($sformatf("rnd%0d ciclo terminado", it), ciclo, (g == 0) ? 9 : 17);
      check($sformatf("rnd%0d errores", it), err_o[g], e_err);
      check($sformatf("rnd%0d mapa", it), map_o[g], e_map);
      check($sformatf("rnd%0d aprobado", it), apr_o[g], (e_err == 0));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
